tmds_align_dec: RTL and testbench
=================================

TMDS_ALIGN_DEC -- requirements
Module: tmds_align_dec

Interface
REQ-001 SHALL provide parameter TOKEN_RUN, default 8: consecutive control tokens needed to declare lock.
REQ-002 SHALL provide parameter SEARCH_LEN, default 1024: cycles without lock (SEARCH) or without any token (LOCKED) before acting.
REQ-003 SHALL provide parameter SLIP_WAIT, default 4: idle cycles after each bitslip pulse.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  pixel clock; all logic on rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: raw  input  10  deserialized word each clk, raw[0] first on the wire.
REQ-008 Port: relock  input  1  forces a return to SEARCH.
REQ-009 Port: bitslip  output  1  one-cycle pulse to the deserializer, shifting word boundary by one bit.
REQ-010 Port: locked  output  1  alignment achieved.
REQ-011 Port: enc  output  10  registered copy of raw.
REQ-012 Port: dec  output  8  decoded data byte.
REQ-013 Port: ctl  output  2  last control token value.
REQ-014 Port: de  output  1  1 = data word, 0 = control token.
REQ-015 Port: slip_cnt  output  4  bitslips issued since last lock, modulo 10 (wraps 9->0).

Function
REQ-016 Token table raw[9:0]: 1101010100->ctl 00, 0010101011->01, 0101010100->10, 1010101011->11.
REQ-017 Decode: d = raw[9] ? ~raw[7:0] : raw[7:0]; dec[0]=d[0]; dec[i] = raw[8] ? d[i]^d[i-1] : d[i]~^d[i-1], i=1..7.
REQ-018 enc, dec, de, ctl SHALL register raw at cycle N and present it at N+1; fixed latency 1, independent of state.
REQ-019 Token word: de=0, ctl=token value, dec=8'h00.
REQ-020 Non-token word: de=1, ctl holds its previous value, dec=decoded byte.
REQ-021 Token run counter: +1 per token word; cleared by any non-token word; saturates at TOKEN_RUN.
REQ-022 States: SEARCH, SLIP, WAIT, LOCKED.
REQ-023 SEARCH: window counter +1 per cycle; run reaching TOKEN_RUN -> LOCKED next cycle, locked=1, slip_cnt=0.
REQ-024 SEARCH: window counter reaching SEARCH_LEN-1 without lock -> SLIP.
REQ-025 Lock and window expiry in the same cycle: lock wins.
REQ-026 SLIP: bitslip=1 for exactly one cycle; slip_cnt increments; -> WAIT.
REQ-027 WAIT: SLIP_WAIT cycles, bitslip=0, run and window counters held at 0; -> SEARCH.
REQ-028 LOCKED: window counter cleared on every token word; SEARCH_LEN cycles with no token -> SEARCH, locked=0 next cycle.
REQ-029 relock=1 in any state: next state SEARCH, locked=0, counters (not slip_cnt) cleared, no bitslip that cycle; overrides REQ-023..028.
REQ-030 bitslip SHALL never assert in two consecutive cycles nor outside SLIP.
REQ-031 Window counter width SHALL be ceil(log2(SEARCH_LEN)); no wrap other than explicit clears.

Reset
REQ-032 rst_n=0 SHALL immediately force state SEARCH and clear all counters.
REQ-033 During reset, all outputs 0: bitslip, locked, enc, dec, ctl, de, slip_cnt.
REQ-034 Reset mid-operation (including during SLIP or WAIT) SHALL abort the operation; first post-reset cycle behaves as a fresh SEARCH.

Verification
REQ-035 Aligned stream, 8 tokens 1101010100 then data -> locked=1 on cycle after the 8th token, slip_cnt=0, bitslip never asserted.
REQ-036 Word 0100000000 (raw[9]=0, raw[8]=1, raw[7:0]=0) -> one cycle later dec=8'h00, de=1, enc=0100000000; token 0010101011 -> de=0, ctl=01, dec=8'h00.
REQ-037 Stream misaligned by 3 bits, model rotates 1 bit per bitslip -> exactly 3 bitslip pulses, each followed by >=4 idle cycles; locked=1; slip_cnt=3.
REQ-038 7 tokens, 1 data word, 8 tokens -> no lock after the first 7; lock after the 8th token of the second run.
REQ-039 Locked, then 1024 cycles with no token -> locked=0 at cycle 1025, SEARCH resumes, bitslip after a further 1024 cycles.
REQ-040 relock pulse while locked, and rst_n low during WAIT -> locked=0 next cycle; no bitslip that cycle; all outputs 0 while rst_n=0.

Source files
------------

// File: rtl/tmds_align_dec.sv
// ---------------------------------------------------------------------------
// tmds_align_dec
//
// Word aligner and decoder for one TMDS channel. A 10-bit word arrives from
// the deserializer every pixel clock. The block hunts for the word boundary
// by looking for runs of control tokens. If no run shows up within a search
// window, it pulses bitslip so the deserializer moves the boundary by one
// bit. Once a run is found it reports lock. Lock is dropped when no control
// token has been seen for a full window.
//
// Every word is decoded regardless of alignment state. The registered
// outputs enc/dec/ctl/de always lag raw by exactly one clock.
//
// Parameters
//   TOKEN_RUN  : consecutive control tokens that declare lock
//   SEARCH_LEN : window length (cycles) for search timeout and token loss (>= 2)
//   SLIP_WAIT  : idle cycles after each bitslip pulse (>= 1)
//
// Ports
//   clk      in   pixel clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   raw      in   10-bit deserialized word, raw[0] first on the wire
//   relock   in   forces the aligner back into search
//   bitslip  out  one-cycle pulse asking the deserializer to shift by one bit
//   locked   out  word alignment achieved
//   enc      out  registered copy of raw
//   dec      out  decoded data byte (0 for control tokens)
//   ctl      out  most recent control token value
//   de       out  1 = data word, 0 = control token
//   slip_cnt out  bitslips issued since the last lock, wraps 9 -> 0
// ---------------------------------------------------------------------------
module tmds_align_dec #(
   parameter int TOKEN_RUN  = 8,
   parameter int SEARCH_LEN = 1024,
   parameter int SLIP_WAIT  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] raw,
   input  logic       relock,
   output logic       bitslip,
   output logic       locked,
   output logic [9:0] enc,
   output logic [7:0] dec,
   output logic [1:0] ctl,
   output logic       de,
   output logic [3:0] slip_cnt
);

   localparam int WIN_W  = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
   localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
   localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   localparam logic [WIN_W-1:0]  WIN_ZERO  = {WIN_W{1'b0}};
   localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_LEN - 1);
   localparam logic [RUN_W-1:0]  RUN_ZERO  = {RUN_W{1'b0}};
   localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
   localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(TOKEN_RUN);
   localparam logic [RUN_W-1:0]  RUN_PRE   = RUN_W'(TOKEN_RUN - 1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_SLIP   = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
   function automatic logic [7:0] tmds_decode(input logic [9:0] w);
      logic [7:0] d;
      logic [7:0] r;
      d    = w[9] ? ~w[7:0] : w[7:0];
      r    = 8'h00;
      r[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         r[i] = w[8] ? (d[i] ^ d[i-1]) : (d[i] ~^ d[i-1]);
      end
      return r;
   endfunction

   // Control token lookup: {hit, value}.
   function automatic logic [2:0] token_lookup(input logic [9:0] w);
      logic [2:0] t;
      case (w)
         10'b1101010100: t = {1'b1, 2'b00};
         10'b0010101011: t = {1'b1, 2'b01};
         10'b0101010100: t = {1'b1, 2'b10};
         10'b1010101011: t = {1'b1, 2'b11};
         default:        t = {1'b0, 2'b00};
      endcase
      return t;
   endfunction

   logic [1:0]        state_r;
   logic [1:0]        state_next_s;
   logic [WIN_W-1:0]  win_r;
   logic [WIN_W-1:0]  win_next_s;
   logic [RUN_W-1:0]  run_r;
   logic [RUN_W-1:0]  run_next_s;
   logic [RUN_W-1:0]  run_inc_s;
   logic [WAIT_W-1:0] wait_r;
   logic [WAIT_W-1:0] wait_next_s;
   logic [3:0]        slip_cnt_r;
   logic [3:0]        slip_next_s;
   logic [2:0]        tok_s;
   logic              is_token_s;
   logic              lock_hit_s;

   logic              bitslip_r;
   logic              locked_r;
   logic [9:0]        enc_r;
   logic [7:0]        dec_r;
   logic [1:0]        ctl_r;
   logic              de_r;

   assign tok_s      = token_lookup(raw);
   assign is_token_s = tok_s[2];
   assign run_inc_s  = (run_r == RUN_FULL) ? RUN_FULL : (run_r + RUN_ONE);
   // The token in this cycle completes the run, so lock shows up together with
   // the registered copy of that token.
   assign lock_hit_s = is_token_s && (run_r >= RUN_PRE);

   // Next-state and counter logic; relock overrides every state's own rule.
   always_comb begin
      state_next_s = state_r;
      win_next_s   = win_r;
      wait_next_s  = wait_r;
      run_next_s   = is_token_s ? run_inc_s : RUN_ZERO;
      if (relock) begin
         state_next_s = ST_SEARCH;
         win_next_s   = WIN_ZERO;
         wait_next_s  = WAIT_ZERO;
         run_next_s   = RUN_ZERO;
      end else begin
         case (state_r)
            ST_SEARCH: begin
               if (lock_hit_s) begin
                  state_next_s = ST_LOCKED;
                  win_next_s   = WIN_ZERO;
               end else if (win_r == WIN_LAST) begin
                  state_next_s = ST_SLIP;
                  win_next_s   = WIN_ZERO;
                  run_next_s   = RUN_ZERO;
               end else begin
                  win_next_s   = win_r + WIN_ONE;
               end
            end
            ST_SLIP: begin
               state_next_s = ST_WAIT;
               wait_next_s  = WAIT_ZERO;
               win_next_s   = WIN_ZERO;
               run_next_s   = RUN_ZERO;
            end
            ST_WAIT: begin
               // Words arriving while the deserializer settles are ignored.
               win_next_s = WIN_ZERO;
               run_next_s = RUN_ZERO;
               if (wait_r == WAIT_LAST) begin
                  state_next_s = ST_SEARCH;
                  wait_next_s  = WAIT_ZERO;
               end else begin
                  wait_next_s  = wait_r + WAIT_ONE;
               end
            end
            ST_LOCKED: begin
               // Window counts consecutive token-free words.
               if (is_token_s) begin
                  win_next_s = WIN_ZERO;
               end else if (win_r == WIN_LAST) begin
                  state_next_s = ST_SEARCH;
                  win_next_s   = WIN_ZERO;
               end else begin
                  win_next_s   = win_r + WIN_ONE;
               end
            end
            default: begin
               state_next_s = ST_SEARCH;
               win_next_s   = WIN_ZERO;
               wait_next_s  = WAIT_ZERO;
               run_next_s   = RUN_ZERO;
            end
         endcase
      end
   end

   // Slip counter: decimal wrap on each slip, cleared when lock is declared.
   always_comb begin
      slip_next_s = slip_cnt_r;
      if (state_next_s == ST_SLIP) begin
         slip_next_s = (slip_cnt_r == 4'd9) ? 4'd0 : (slip_cnt_r + 4'd1);
      end else if ((state_r == ST_SEARCH) && (state_next_s == ST_LOCKED)) begin
         slip_next_s = 4'd0;
      end else begin
         slip_next_s = slip_cnt_r;
      end
   end

   // Control state, counters and the state-derived outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_SEARCH;
         win_r      <= WIN_ZERO;
         run_r      <= RUN_ZERO;
         wait_r     <= WAIT_ZERO;
         slip_cnt_r <= 4'd0;
         bitslip_r  <= 1'b0;
         locked_r   <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         win_r      <= win_next_s;
         run_r      <= run_next_s;
         wait_r     <= wait_next_s;
         slip_cnt_r <= slip_next_s;
         // The pulse is high exactly during the single SLIP-state cycle.
         bitslip_r  <= (state_next_s == ST_SLIP);
         locked_r   <= (state_next_s == ST_LOCKED);
      end
   end

   // Decode pipeline: one-cycle latency, independent of alignment state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_r <= 10'd0;
         dec_r <= 8'h00;
         ctl_r <= 2'b00;
         de_r  <= 1'b0;
      end else begin
         enc_r <= raw;
         if (is_token_s) begin
            de_r  <= 1'b0;
            ctl_r <= tok_s[1:0];
            dec_r <= 8'h00;
         end else begin
            de_r  <= 1'b1;
            ctl_r <= ctl_r;
            dec_r <= tmds_decode(raw);
         end
      end
   end

   assign bitslip  = bitslip_r;
   assign locked   = locked_r;
   assign enc      = enc_r;
   assign dec      = dec_r;
   assign ctl      = ctl_r;
   assign de       = de_r;
   assign slip_cnt = slip_cnt_r;

endmodule

// File: tb/tb_tmds_align_dec.sv
// ---------------------------------------------------------------------------
// tb_tmds_align_dec
//
// Directed sequence with randomized data words, checked every cycle against
// a behavioural model that tracks the aligner as a handful of counters
// (tokens in a row, cycles searched, cycles of post-slip pause, token-free
// cycles while locked) rather than as a state machine.
// ---------------------------------------------------------------------------
module tb_tmds_align_dec;

   localparam int TOKEN_RUN  = 8;
   localparam int SEARCH_LEN = 1024;
   localparam int SLIP_WAIT  = 4;

   localparam logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

   logic       clk;
   logic       rst_n;
   logic [9:0] raw;
   logic       relock;
   logic       bitslip;
   logic       locked;
   logic [9:0] enc;
   logic [7:0] dec;
   logic [1:0] ctl;
   logic       de;
   logic [3:0] slip_cnt;

   tmds_align_dec #(
      .TOKEN_RUN (TOKEN_RUN),
      .SEARCH_LEN(SEARCH_LEN),
      .SLIP_WAIT (SLIP_WAIT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (raw),
      .relock  (relock),
      .bitslip (bitslip),
      .locked  (locked),
      .enc     (enc),
      .dec     (dec),
      .ctl     (ctl),
      .de      (de),
      .slip_cnt(slip_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int    n_cmp;
   int    n_err;
   string phase;

   // model state
   logic       e_bitslip, e_locked, e_de;
   logic [9:0] e_enc;
   logic [7:0] e_dec;
   logic [1:0] e_ctl;
   int         m_slips, m_cool, m_streak, m_age, m_quiet;

   task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs_v === exp_v) else begin
         n_err++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs_v, exp_v);
      end
   endtask

   function automatic int token_of(input logic [9:0] w);
      for (int i = 0; i < 4; i++) begin
         if (w == TOKS[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] w);
      logic [7:0] d;
      logic [7:0] r;
      d = w[9] ? ~w[7:0] : w[7:0];
      r = 8'h00;
      r[0] = d[0];
      for (int i = 1; i < 8; i++) r[i] = w[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
      return r;
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = 10'($urandom); while (token_of(w) >= 0);
      return w;
   endfunction

   // Word seen by a deserializer whose boundary is 'off' bits late.
   function automatic logic [9:0] rot_word(input logic [9:0] w, input int off);
      logic [19:0] dbl;
      dbl = {w, w} >> off;
      return dbl[9:0];
   endfunction

   function automatic logic [26:0] obs_vec();
      return {bitslip, locked, enc, dec, ctl, de, slip_cnt};
   endfunction

   function automatic logic [26:0] exp_vec();
      return {e_bitslip, e_locked, e_enc, e_dec, e_ctl, e_de, 4'(m_slips)};
   endfunction

   task automatic model_reset();
      e_bitslip = 1'b0; e_locked = 1'b0; e_de = 1'b0;
      e_enc = 10'd0; e_dec = 8'h00; e_ctl = 2'b00;
      m_slips = 0; m_cool = 0; m_streak = 0; m_age = 0; m_quiet = 0;
   endtask

   // Expected outputs after one clock edge that sampled word w and relock rl.
   task automatic model_step(input logic [9:0] w, input logic rl);
      int tv;
      tv = token_of(w);
      e_enc = w;
      if (tv >= 0) begin
         e_de = 1'b0; e_ctl = 2'(tv); e_dec = 8'h00;
      end else begin
         e_de = 1'b1; e_dec = ref_decode(w);
      end
      e_bitslip = 1'b0;
      if (rl) begin
         e_locked = 1'b0; m_cool = 0; m_streak = 0; m_age = 0; m_quiet = 0;
      end else if (m_cool > 0) begin
         m_cool--; m_streak = 0; m_age = 0;
      end else if (!e_locked) begin
         m_streak = (tv >= 0) ? m_streak + 1 : 0;
         if (m_streak >= TOKEN_RUN) begin
            e_locked = 1'b1; m_slips = 0; m_quiet = 0; m_age = 0; m_streak = 0;
         end else if (m_age == SEARCH_LEN - 1) begin
            e_bitslip = 1'b1; m_slips = (m_slips + 1) % 10;
            m_cool = SLIP_WAIT + 1; m_age = 0; m_streak = 0;
         end else begin
            m_age++;
         end
      end else begin
         if (tv >= 0) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == SEARCH_LEN) begin
               e_locked = 1'b0; m_quiet = 0; m_age = 0; m_streak = 0;
            end
         end
      end
   endtask

   task automatic tick(input logic [9:0] w, input logic rl);
      raw = w;
      relock = rl;
      @(posedge clk);
      #1;
      model_step(w, rl);
      check("cycle", 32'(obs_vec()), 32'(exp_vec()));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      relock = 1'b0;
      raw = rand_data();
      #1;
      check("rst_async", 32'(obs_vec()), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_hold", 32'(obs_vec()), 32'd0);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int seen, pulses, idle, min_gap, off, last_sc, cyc;
      logic [9:0] w;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      raw = 10'd0;
      relock = 1'b0;
      model_reset();

      phase = "reset";
      apply_reset();

      phase = "decode";
      tick(10'b0100000000, 1'b0);
      check("dec_100", 32'(dec), 32'h00);
      check("de_100", 32'(de), 32'd1);
      check("enc_100", 32'(enc), 32'h100);
      tick(10'b0010101011, 1'b0);
      check("ctl_tok01", 32'(ctl), 32'd1);
      check("de_tok01", 32'(de), 32'd0);
      check("dec_tok01", 32'(dec), 32'h00);

      phase = "aligned_lock";
      apply_reset();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick(TOKS[0], 1'b0);
         seen += int'(bitslip);
         if (i == 6) check("nolock_7", 32'(locked), 32'd0);
      end
      check("lock_8", 32'(locked), 32'd1);
      check("slipcnt_0", 32'(slip_cnt), 32'd0);
      check("no_bitslip", 32'(seen), 32'd0);
      for (int i = 0; i < 200; i++) begin
         w = ($urandom_range(0, 9) == 0) ? TOKS[$urandom_range(0, 3)] : rand_data();
         tick(w, 1'b0);
      end
      tick(TOKS[1], 1'b0);
      check("still_locked", 32'(locked), 32'd1);

      phase = "token_loss";
      for (int i = 1; i <= SEARCH_LEN; i++) begin
         tick(rand_data(), 1'b0);
         if (i == SEARCH_LEN - 1) check("locked_1023", 32'(locked), 32'd1);
      end
      check("unlock_1025", 32'(locked), 32'd0);
      seen = 0;
      for (int i = 1; i < SEARCH_LEN; i++) begin
         tick(rand_data(), 1'b0);
         seen += int'(bitslip);
      end
      check("no_early_slip", 32'(seen), 32'd0);
      tick(rand_data(), 1'b0);
      check("slip_after_window", 32'(bitslip), 32'd1);

      phase = "broken_run";
      apply_reset();
      for (int i = 0; i < 7; i++) tick(TOKS[$urandom_range(0, 3)], 1'b0);
      check("nolock_run7", 32'(locked), 32'd0);
      tick(rand_data(), 1'b0);
      for (int i = 0; i < 7; i++) tick(TOKS[$urandom_range(0, 3)], 1'b0);
      check("nolock_after_gap", 32'(locked), 32'd0);
      tick(TOKS[$urandom_range(0, 3)], 1'b0);
      check("lock_run8", 32'(locked), 32'd1);

      phase = "relock";
      tick(TOKS[2], 1'b1);
      check("relock_unlock", 32'(locked), 32'd0);
      check("relock_noslip", 32'(bitslip), 32'd0);
      for (int i = 0; i < 8; i++) tick(TOKS[0], 1'b0);
      check("relock_lock", 32'(locked), 32'd1);

      phase = "misaligned";
      apply_reset();
      off = 3; pulses = 0; idle = 0; min_gap = 1 << 30; last_sc = -1; cyc = 0;
      while (!locked && cyc < 8000) begin
         tick(rot_word(TOKS[0], off), 1'b0);
         cyc++;
         if (bitslip) begin
            if (pulses > 0 && idle < min_gap) min_gap = idle;
            pulses++;
            idle = 0;
         end else begin
            idle++;
         end
         if (e_bitslip) off = (off + 9) % 10;
         if (!locked) last_sc = int'(slip_cnt);
      end
      if (idle < min_gap) min_gap = idle;
      check("mis_locked", 32'(locked), 32'd1);
      check("mis_pulses", 32'(pulses), 32'd3);
      check("mis_slipcnt_prelock", 32'(last_sc), 32'd3);
      check("mis_gap_ok", 32'(min_gap >= SLIP_WAIT), 32'd1);
      check("mis_slipcnt_lock", 32'(slip_cnt), 32'd0);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         w = ($urandom_range(0, 99) < 60) ? TOKS[$urandom_range(0, 3)] : rand_data();
         tick(w, $urandom_range(0, 199) == 0);
      end

      phase = "slip_wrap";
      apply_reset();
      pulses = 0; cyc = 0;
      while (pulses < 10 && cyc < 12000) begin
         tick(rand_data(), 1'b0);
         cyc++;
         pulses += int'(bitslip);
      end
      check("wrap_pulses", 32'(pulses), 32'd10);
      check("wrap_slipcnt", 32'(slip_cnt), 32'd0);
      tick(rand_data(), 1'b0);
      tick(rand_data(), 1'b0);

      phase = "reset_in_wait";
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         tick(TOKS[3], 1'b0);
         if (i == 6) check("fresh_nolock7", 32'(locked), 32'd0);
      end
      check("fresh_lock", 32'(locked), 32'd1);
      check("fresh_slipcnt", 32'(slip_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
